// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 full slave backed by an on-chip register-array memory.
// One outstanding burst per direction; read and write engines run independently.
// Every beat is a full DATA_WIDTH word, and awsize/arsize are ignored.
// FIXED bursts keep the word index constant. INCR and WRAP bursts step the index by one word per beat.
// Optional feature macro: AXI_SLV_RANGE_CHECK_EN.
//   Defined: out-of-range bursts suppress writes, read back zero data, and return SLVERR.
//   Undefined: the upper address bits alias onto the memory, and responses are always OKAY.
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ap_clk,
  input  logic                    ap_rstn,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int NB_LOG = $clog2(NB);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int WA_W   = ADDR_WIDTH - NB_LOG;

`ifdef AXI_SLV_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // True when the last word touched by the burst lies beyond the memory.
  function automatic logic range_err(input logic [WA_W-1:0] word, input logic [7:0] len,
                                     input logic [1:0] burst);
    logic [WA_W:0] last_word;
    logic [7:0]    span;
    span      = (burst == 2'b00) ? 8'd0 : len;
    last_word = {1'b0, word} + {{(WA_W-7){1'b0}}, span};
    return last_word >= (WA_W+1)'(MEM_DEPTH);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  w_state_t            w_state_r, w_next_s;
  logic [ID_WIDTH-1:0] w_id_r, bid_r;
  logic [IDX_W-1:0]    w_idx_r, aw_idx_s, w_step_s;
  logic [7:0]          w_len_r, w_cnt_r;
  logic                w_fixed_r, w_err_r, aw_err_s;
  logic                awready_r, wready_r, bvalid_r;
  logic [1:0]          bresp_r;
  logic                aw_hs_s, w_hs_s, b_hs_s;

  r_state_t              r_state_r, r_next_s;
  logic [ID_WIDTH-1:0]   rid_r;
  logic [IDX_W-1:0]      r_idx_r, ar_idx_s, ar_step_s, r_step_s;
  logic [7:0]            r_len_r, r_cnt_r;
  logic                  r_fixed_r, r_err_r, ar_err_s;
  logic                  arready_r, rvalid_r, rlast_r;
  logic [1:0]            rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  ar_hs_s, r_hs_s;
  logic                  unused_s;

  assign aw_hs_s   = awready_r & s_axi_awvalid;
  assign w_hs_s    = wready_r & s_axi_wvalid;
  assign b_hs_s    = bvalid_r & s_axi_bready;
  assign ar_hs_s   = arready_r & s_axi_arvalid;
  assign r_hs_s    = rvalid_r & s_axi_rready;
  assign aw_idx_s  = s_axi_awaddr[NB_LOG +: IDX_W];
  assign ar_idx_s  = s_axi_araddr[NB_LOG +: IDX_W];
  assign aw_err_s  = RANGE_EN & range_err(s_axi_awaddr[ADDR_WIDTH-1:NB_LOG], s_axi_awlen, s_axi_awburst);
  assign ar_err_s  = RANGE_EN & range_err(s_axi_araddr[ADDR_WIDTH-1:NB_LOG], s_axi_arlen, s_axi_arburst);
  assign w_step_s  = {{(IDX_W-1){1'b0}}, ~w_fixed_r};
  assign r_step_s  = {{(IDX_W-1){1'b0}}, ~r_fixed_r};
  assign ar_step_s = {{(IDX_W-1){1'b0}}, (s_axi_arburst != 2'b00)};
  assign unused_s  = ^{s_axi_awsize, s_axi_arsize, s_axi_wlast,
                       s_axi_awaddr[NB_LOG-1:0], s_axi_araddr[NB_LOG-1:0]};

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bid     = bid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rid     = rid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rlast   = rlast_r;

  // Byte-lane writes into the memory array on every accepted, non-erroring W beat.
  always_ff @(posedge ap_clk) begin
    if (w_hs_s && !w_err_r) begin
      for (int i = 0; i < NB; i++) begin
        if (s_axi_wstrb[i]) begin
          mem_r[w_idx_r][8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
      end
    end
  end

  // Write FSM next state: the beat count, not wlast, ends the data phase.
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
      W_DATA: if (w_hs_s && (w_cnt_r == w_len_r)) w_next_s = W_RESP; else w_next_s = W_DATA;
      W_RESP: if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write FSM state, burst context and registered AW/W/B handshake outputs.
  always_ff @(posedge ap_clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= {ID_WIDTH{1'b0}};
      bresp_r   <= 2'b00;
      w_id_r    <= {ID_WIDTH{1'b0}};
      w_idx_r   <= {IDX_W{1'b0}};
      w_len_r   <= 8'd0;
      w_cnt_r   <= 8'd0;
      w_fixed_r <= 1'b0;
      w_err_r   <= 1'b0;
    end else begin
      w_state_r <= w_next_s;
      awready_r <= (w_next_s == W_IDLE);
      wready_r  <= (w_next_s == W_DATA);
      bvalid_r  <= (w_next_s == W_RESP);
      if (aw_hs_s) begin
        w_id_r    <= s_axi_awid;
        w_idx_r   <= aw_idx_s;
        w_len_r   <= s_axi_awlen;
        w_cnt_r   <= 8'd0;
        w_fixed_r <= (s_axi_awburst == 2'b00);
        w_err_r   <= aw_err_s;
      end else if (w_hs_s) begin
        w_cnt_r <= w_cnt_r + 8'd1;
        w_idx_r <= w_idx_r + w_step_s;
      end
      if (w_hs_s && (w_cnt_r == w_len_r)) begin
        bid_r   <= w_id_r;
        bresp_r <= w_err_r ? 2'b10 : 2'b00;
      end
    end
  end

  // Read FSM next state: leave the data phase on the handshake of the last beat.
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: if (ar_hs_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
      R_DATA: if (r_hs_s && rlast_r) r_next_s = R_IDLE; else r_next_s = R_DATA;
      default: r_next_s = R_IDLE;
    endcase
  end

  // Read FSM state and R beat registers; r_idx_r always points at the next beat to load.
  always_ff @(posedge ap_clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= 2'b00;
      rid_r     <= {ID_WIDTH{1'b0}};
      rdata_r   <= {DATA_WIDTH{1'b0}};
      r_idx_r   <= {IDX_W{1'b0}};
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      r_fixed_r <= 1'b0;
      r_err_r   <= 1'b0;
    end else begin
      r_state_r <= r_next_s;
      arready_r <= (r_next_s == R_IDLE);
      if (ar_hs_s) begin
        rid_r     <= s_axi_arid;
        r_len_r   <= s_axi_arlen;
        r_cnt_r   <= 8'd0;
        r_fixed_r <= (s_axi_arburst == 2'b00);
        r_err_r   <= ar_err_s;
        rvalid_r  <= 1'b1;
        rlast_r   <= (s_axi_arlen == 8'd0);
        rresp_r   <= ar_err_s ? 2'b10 : 2'b00;
        rdata_r   <= ar_err_s ? {DATA_WIDTH{1'b0}} : mem_r[ar_idx_s];
        r_idx_r   <= ar_idx_s + ar_step_s;
      end else if (r_hs_s) begin
        if (rlast_r) begin
          rvalid_r <= 1'b0;
          rlast_r  <= 1'b0;
        end else begin
          r_cnt_r <= r_cnt_r + 8'd1;
          rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
          rdata_r <= r_err_r ? {DATA_WIDTH{1'b0}} : mem_r[r_idx_r];
          r_idx_r <= r_idx_r + r_step_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized AXI traffic against a word-array reference model.
// Expected B/R responses are queued when stimulus is issued; a monitor pops and compares them.
// Honours AXI_SLV_RANGE_CHECK_EN in its model.
module tb_axi_sram_slave;

  logic         ap_clk = 1'b0;
  logic         ap_rstn;
  logic [3:0]   s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0]  s_axi_awaddr, s_axi_araddr;
  logic [7:0]   s_axi_awlen, s_axi_arlen;
  logic [2:0]   s_axi_awsize, s_axi_arsize;
  logic [1:0]   s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic         s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic         s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [255:0] s_axi_wdata, s_axi_rdata;
  logic [31:0]  s_axi_wstrb;

  always #5 ap_clk = ~ap_clk;

  axi_sram_slave dut (
    .ap_clk(ap_clk), .ap_rstn(ap_rstn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

`ifdef AXI_SLV_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [3:0] id; logic [255:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t       b_q[$];
  r_exp_t       r_q[$];
  logic [255:0] model_mem [1024];
  logic [255:0] wdata_a [256];
  logic [31:0]  wstrb_a [256];
  int           n_checks = 0;
  int           n_fail = 0;
  int           rready_mode = 0;
  bit           gap_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the word touched by beat k, and whether the burst falls outside the memory.
  function automatic int beat_word(input logic [31:0] addr, input int k, input logic [1:0] burst);
    longint w;
    w = longint'(addr / 32) + ((burst == 2'd0) ? 0 : k);
    return int'(w % 1024);
  endfunction

  function automatic bit range_bad(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    longint last;
    last = longint'(addr / 32) + ((burst == 2'd0) ? 0 : longint'(len));
    return RC && (last >= 1024);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, s_axi_awready, 0);
    chk({tag, "_wready"},  s_axi_wready, 0);
    chk({tag, "_bvalid"},  s_axi_bvalid, 0);
    chk({tag, "_bid"},     s_axi_bid, 0);
    chk({tag, "_bresp"},   s_axi_bresp, 0);
    chk({tag, "_arready"}, s_axi_arready, 0);
    chk({tag, "_rvalid"},  s_axi_rvalid, 0);
    chk({tag, "_rid"},     s_axi_rid, 0);
    chk({tag, "_rdata"},   s_axi_rdata, 0);
    chk({tag, "_rresp"},   s_axi_rresp, 0);
    chk({tag, "_rlast"},   s_axi_rlast, 0);
  endtask

  // Ready generators for the B and R channels.
  initial begin
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    forever begin
      @(posedge ap_clk);
      #1;
      s_axi_bready = 1'($urandom_range(0, 1));
      case (rready_mode)
        0: s_axi_rready = 1'b1;
        1: s_axi_rready = ~s_axi_rready;
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare each B/R handshake against the scoreboard; R must hold while stalled.
  bit           prev_stall = 1'b0;
  logic [255:0] prev_data;
  logic         prev_last;
  always @(negedge ap_clk) begin
    if (!ap_rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("r_stall_data", s_axi_rdata, prev_data);
        chk("r_stall_last", s_axi_rlast, prev_last);
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (b_q.size() == 0) begin
          chk("b_unexpected", 1, 0);
        end else begin
          b_exp_t e;
          e = b_q.pop_front();
          chk("bid", s_axi_bid, e.id);
          chk("bresp", s_axi_bresp, e.resp);
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (r_q.size() == 0) begin
          chk("r_unexpected", 1, 0);
        end else begin
          r_exp_t e;
          e = r_q.pop_front();
          chk("rid", s_axi_rid, e.id);
          chk("rdata", s_axi_rdata, e.data);
          chk("rresp", s_axi_rresp, e.resp);
          chk("rlast", s_axi_rlast, e.last);
        end
      end
      prev_stall = s_axi_rvalid && !s_axi_rready;
      prev_data  = s_axi_rdata;
      prev_last  = s_axi_rlast;
    end
  end

  // Write burst from wdata_a/wstrb_a; rst_after >= 0 pulses reset after that beat.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int rst_after);
    int to;
    bit err;
    err = range_bad(addr, len, burst);
    @(posedge ap_clk); #1;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awburst = burst; s_axi_awsize = 3'd5; s_axi_awvalid = 1'b1;
    to = 0;
    do begin @(negedge ap_clk); to++; end while (!s_axi_awready && to < 200);
    if (to >= 200) chk("aw_timeout", 1, 0);
    @(posedge ap_clk); #1;
    s_axi_awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin @(posedge ap_clk); #1; end
      s_axi_wdata = wdata_a[k]; s_axi_wstrb = wstrb_a[k];
      s_axi_wlast = (k == int'(len)); s_axi_wvalid = 1'b1;
      to = 0;
      do begin @(negedge ap_clk); to++; end while (!s_axi_wready && to < 200);
      if (to >= 200) chk("w_timeout", 1, 0);
      @(posedge ap_clk);
      if (!err) begin
        for (int b = 0; b < 32; b++) begin
          if (wstrb_a[k][b]) model_mem[beat_word(addr, k, burst)][8*b +: 8] = wdata_a[k][8*b +: 8];
        end
      end
      if (k == int'(len)) b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
      #1;
      s_axi_wvalid = 1'b0;
      if (k == rst_after) begin
        ap_rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rstn = 1'b1;
        return;
      end
    end
    to = 0;
    while (b_q.size() != 0 && to < 300) begin @(negedge ap_clk); #1; to++; end
    chk("b_timeout", b_q.size(), 0);
  endtask

  // Read burst: queue expectations from the model, issue AR, wait until every beat is seen.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
    int to;
    int cycles;
    bit err;
    err = range_bad(addr, len, burst);
    for (int k = 0; k <= int'(len); k++) begin
      r_q.push_back('{id: id, data: err ? 256'd0 : model_mem[beat_word(addr, k, burst)],
                      resp: err ? 2'b10 : 2'b00, last: (k == int'(len))});
    end
    @(posedge ap_clk); #1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arburst = burst; s_axi_arsize = 3'd5; s_axi_arvalid = 1'b1;
    to = 0;
    do begin @(negedge ap_clk); to++; end while (!s_axi_arready && to < 200);
    if (to >= 200) chk("ar_timeout", 1, 0);
    @(posedge ap_clk); #1;
    s_axi_arvalid = 1'b0;
    @(negedge ap_clk); #1;
    chk("r_latency", s_axi_rvalid, 1);
    cycles = 1;
    while (r_q.size() != 0 && cycles < 3000) begin @(negedge ap_clk); #1; cycles++; end
    chk("r_timeout", r_q.size(), 0);
    if (rready_mode == 0) chk("r_back_to_back", cycles, int'(len) + 1);
    @(posedge ap_clk); #1;
    chk("r_idle_after_last", s_axi_rvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rstn = 1'b0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_awid = 4'd0; s_axi_awaddr = 32'd0; s_axi_awlen = 8'd0; s_axi_awsize = 3'd0; s_axi_awburst = 2'd0;
    s_axi_arid = 4'd0; s_axi_araddr = 32'd0; s_axi_arlen = 8'd0; s_axi_arsize = 3'd0; s_axi_arburst = 2'd0;
    s_axi_wdata = 256'd0; s_axi_wstrb = 32'd0; s_axi_wlast = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk_all_zero("reset");
    ap_rstn = 1'b1;

    // Fill the whole memory so every later read has a known expectation.
    for (int blk = 0; blk < 4; blk++) begin
      for (int k = 0; k < 256; k++) begin
        wdata_a[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        wstrb_a[k] = 32'hFFFF_FFFF;
      end
      axi_write(4'(blk), 32'(blk * 256 * 32), 8'd255, 2'd1, -1);
    end

    // Words 2..5 receive k; read back with rready held high.
    for (int k = 0; k < 4; k++) begin wdata_a[k] = 256'(k); wstrb_a[k] = 32'hFFFF_FFFF; end
    axi_write(4'd5, 32'h40, 8'd3, 2'd1, -1);
    axi_read(4'd9, 32'h40, 8'd3, 2'd1);

    // Partial strobe over a word preloaded with 0xAA bytes.
    wdata_a[0] = {32{8'hAA}}; wstrb_a[0] = 32'hFFFF_FFFF;
    axi_write(4'd1, 32'h140, 8'd0, 2'd1, -1);
    wdata_a[0] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    wstrb_a[0] = 32'h0000_FFFF;
    axi_write(4'd2, 32'h140, 8'd0, 2'd1, -1);
    axi_read(4'd3, 32'h140, 8'd0, 2'd1);

    // 8-beat read with rready toggling every cycle.
    rready_mode = 1;
    axi_read(4'd7, 32'h800, 8'd7, 2'd1);

    // Randomized bursts with W gaps and random R back-pressure, including FIXED and aliasing addresses.
    gap_en = 1'b1;
    rready_mode = 2;
    for (int t = 0; t < 20; t++) begin
      logic [31:0] a;
      logic [7:0]  l;
      logic [1:0]  bu;
      a  = 32'($urandom_range(0, 2 * 1024 * 32 - 1));
      l  = 8'($urandom_range(0, 15));
      bu = 2'($urandom_range(0, 2));
      for (int k = 0; k < 16; k++) begin
        wdata_a[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        wstrb_a[k] = $urandom;
      end
      axi_write(4'($urandom), a, l, bu, -1);
      axi_read(4'($urandom), a, l, bu);
      axi_read(4'($urandom), 32'($urandom_range(0, 2 * 1024 * 32 - 1)), 8'($urandom_range(0, 15)),
               2'($urandom_range(0, 2)));
    end

    // Reset pulse after beat 5 of a 16-beat write: beats 0..5 stay, no B issued.
    gap_en = 1'b0;
    rready_mode = 0;
    for (int k = 0; k < 16; k++) begin
      wdata_a[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      wstrb_a[k] = 32'hFFFF_FFFF;
    end
    axi_write(4'd4, 32'h1000, 8'd15, 2'd1, 5);
    repeat (2) @(posedge ap_clk);
    chk("midrst_no_b", b_q.size(), 0);
    axi_read(4'd6, 32'h1000, 8'd15, 2'd1);
    axi_write(4'd8, 32'h2000, 8'd3, 2'd1, -1);
    axi_read(4'd8, 32'h2000, 8'd3, 2'd1);

    // First word beyond the memory: aliases to word 0/1, or errors with range checking.
    axi_read(4'd10, 32'(1024 * 32), 8'd1, 2'd1);

    repeat (5) @(posedge ap_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
